// File: rtl/scramble_ctrl.sv
// Symbol scrambler with ordered-set tracking: LFSR G(X)=X^16+X^5+X^4+X^3+1,
// one-cycle registered datapath, COM/SKP/TS detection to gate scrambling.
//
// state  | meaning
// RUN    | normal traffic; D symbols scrambled, LFSR advances per symbol
// OS_HDR | symbol after COM; classifies the ordered set
// SKP    | inside a SKP ordered set; LFSR frozen
// TS     | inside a training set; unscrambled, LFSR advances, counter runs
module scramble_ctrl (
  input  logic        ClkPci,
  input  logic        notResetPci,
  input  logic        InValid,
  input  logic [7:0]  InData,
  input  logic        InK,
  input  logic        ScrambleDisable,
  output logic        OutValid,
  output logic [7:0]  OutData,
  output logic        OutK,
  output logic [15:0] LfsrState,
  output logic [1:0]  CtrlState
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_OS_HDR = 2'd1,
    ST_SKP    = 2'd2,
    ST_TS     = 2'd3
  } state_e;

  localparam logic [7:0]  K_COM     = 8'hBC;
  localparam logic [7:0]  K_SKP     = 8'h1C;
  localparam logic [7:0]  K_FTS     = 8'h3C;
  localparam logic [7:0]  K_IDL     = 8'h7C;
  localparam logic [7:0]  K_PAD     = 8'hF7;
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  localparam logic [3:0]  TS_LOAD   = 4'd14;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  ts_cnt_q, ts_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_k_q, out_k_d;

  logic        advance;
  logic        run_sym;

  // Eight serial shifts of the Galois LFSR collapsed into one step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] hi;
    hi = {8'h00, s[15:8]};
    return {s[7:0], s[15:8]} ^ (hi << 3) ^ (hi << 4) ^ (hi << 5);
  endfunction

  function automatic logic [7:0] bit_rev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    ts_cnt_d    = ts_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_k_d     = out_k_q;
    advance     = 1'b0;
    run_sym     = 1'b0;

    if (InValid) begin
      out_valid_d = 1'b1;
      out_k_d     = InK;
      out_data_d  = InData;

      if (InK && InData == K_COM) begin
        state_d  = ST_OS_HDR;
        ts_cnt_d = 4'd0;
      end else begin
        unique case (state_q)
          ST_RUN: run_sym = 1'b1;
          ST_OS_HDR: begin
            if (InK && InData == K_SKP) begin
              state_d = ST_SKP;
            end else if (!InK || InData == K_PAD) begin
              state_d  = ST_TS;
              ts_cnt_d = TS_LOAD;
              advance  = 1'b1;
            end else begin
              // FTS, IDL and any unrecognised K fall back to normal traffic
              state_d = ST_RUN;
              advance = 1'b1;
            end
          end
          ST_SKP: begin
            if (!(InK && InData == K_SKP)) begin
              state_d = ST_RUN;
              run_sym = 1'b1;
            end
          end
          ST_TS: begin
            advance  = 1'b1;
            ts_cnt_d = ts_cnt_q - 4'd1;
            if (ts_cnt_q <= 4'd1) begin
              state_d  = ST_RUN;
              ts_cnt_d = 4'd0;
            end
          end
          default: state_d = ST_RUN;
        endcase
      end

      if (run_sym) begin
        advance = 1'b1;
        if (!InK && !ScrambleDisable) out_data_d = InData ^ bit_rev(lfsr_q[15:8]);
      end

      if (InK && InData == K_COM) lfsr_d = LFSR_SEED;
      else if (advance)           lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge ClkPci or negedge notResetPci) begin
    if (!notResetPci) begin
      state_q     <= ST_RUN;
      lfsr_q      <= LFSR_SEED;
      ts_cnt_q    <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_k_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      ts_cnt_q    <= ts_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_k_q     <= out_k_d;
    end
  end

  assign OutValid  = out_valid_q;
  assign OutData   = out_data_q;
  assign OutK      = out_k_q;
  assign LfsrState = lfsr_q;
  assign CtrlState = state_q;

endmodule

// File: tb/tb_scramble_ctrl.sv
// Directed bench for scramble_ctrl: hand-computed scrambler bytes and
// ordered-set state sequences, checked one cycle after each symbol.
module tb_scramble_ctrl;

  logic        ClkPci = 1'b0;
  logic        notResetPci = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_k = 1'b0;
  logic        scr_dis = 1'b0;
  logic        OutValid;
  logic [7:0]  OutData;
  logic        OutK;
  logic [15:0] LfsrState;
  logic [1:0]  CtrlState;

  int n_checks = 0;
  int n_fail = 0;

  scramble_ctrl dut (
    .ClkPci          (ClkPci),
    .notResetPci     (notResetPci),
    .InValid         (in_valid),
    .InData          (in_data),
    .InK             (in_k),
    .ScrambleDisable (scr_dis),
    .OutValid        (OutValid),
    .OutData         (OutData),
    .OutK            (OutK),
    .LfsrState       (LfsrState),
    .CtrlState       (CtrlState)
  );

  always #5 ClkPci = ~ClkPci;

  task automatic send(input logic k, input logic [7:0] d, input logic sd);
    @(negedge ClkPci);
    in_valid = 1'b1;
    in_k     = k;
    in_data  = d;
    scr_dis  = sd;
    @(posedge ClkPci);
    #1;
  endtask

  task automatic idle();
    @(negedge ClkPci);
    in_valid = 1'b0;
    in_k     = 1'b0;
    in_data  = 8'h00;
    @(posedge ClkPci);
    #1;
  endtask

  task automatic do_reset();
    @(negedge ClkPci);
    in_valid    = 1'b0;
    scr_dis     = 1'b0;
    notResetPci = 1'b0;
    @(negedge ClkPci);
    notResetPci = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    send(1'b1, 8'h33, 1'b0);
    #2;
    notResetPci = 1'b0;
    #1;
    n_checks++;
    if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", OutValid); end
    n_checks++;
    if (OutData !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", OutData); end
    n_checks++;
    if (OutK !== 1'b0) begin n_fail++; $display("FAIL reset_k: got %b want 0", OutK); end
    n_checks++;
    if (LfsrState !== 16'hFFFF) begin n_fail++; $display("FAIL reset_lfsr: got %h want ffff", LfsrState); end
    n_checks++;
    if (CtrlState !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", CtrlState); end
    @(negedge ClkPci);
    notResetPci = 1'b1;
    in_valid    = 1'b0;
  endtask

  task automatic test_zeros();
    logic [7:0] e [0:2] = '{8'hFF, 8'h17, 8'hC0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 8'h00, 1'b0);
      n_checks++;
      if (OutValid !== 1'b1 || OutData !== e[i]) begin
        n_fail++; $display("FAIL zeros_data[%0d]: got v=%b %h want v=1 %h", i, OutValid, OutData, e[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (LfsrState !== 16'hE817) begin n_fail++; $display("FAIL zeros_lfsr1: got %h want e817", LfsrState); end
      end
    end
    n_checks++;
    if (LfsrState !== 16'h284B) begin n_fail++; $display("FAIL zeros_lfsr3: got %h want 284b", LfsrState); end
    idle();
  endtask

  task automatic test_skp();
    logic       ks [0:4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ds [0:4] = '{8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'h00};
    logic [7:0] eo [0:4] = '{8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'hFF};
    logic [1:0] es [0:4] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(ks[i], ds[i], 1'b0);
      n_checks++;
      if (OutData !== eo[i] || OutK !== ks[i] || CtrlState !== es[i]) begin
        n_fail++;
        $display("FAIL skp[%0d]: got d=%h k=%b st=%0d want d=%h k=%b st=%0d",
                 i, OutData, OutK, CtrlState, eo[i], ks[i], es[i]);
      end
    end
    n_checks++;
    if (LfsrState !== 16'hE817) begin n_fail++; $display("FAIL skp_lfsr: got %h want e817", LfsrState); end
    idle();
  endtask

  task automatic test_ts();
    do_reset();
    send(1'b0, 8'h00, 1'b0);
    send(1'b1, 8'hBC, 1'b0);
    n_checks++;
    if (CtrlState !== 2'd1 || LfsrState !== 16'hFFFF) begin
      n_fail++; $display("FAIL ts_com: got st=%0d lfsr=%h want st=1 lfsr=ffff", CtrlState, LfsrState);
    end
    for (int i = 0; i < 15; i++) begin
      send(1'b0, 8'h4A, 1'b0);
      n_checks++;
      if (OutData !== 8'h4A || CtrlState !== ((i == 14) ? 2'd0 : 2'd3)) begin
        n_fail++;
        $display("FAIL ts_sym[%0d]: got d=%h st=%0d want d=4a st=%0d", i, OutData, CtrlState, (i == 14) ? 0 : 3);
      end
    end
    n_checks++;
    if (LfsrState !== 16'hB165) begin n_fail++; $display("FAIL ts_lfsr: got %h want b165", LfsrState); end
    send(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (OutData !== 8'h8D || CtrlState !== 2'd0) begin
      n_fail++; $display("FAIL ts_after: got d=%h st=%0d want d=8d st=0", OutData, CtrlState);
    end
    idle();
  endtask

  task automatic test_disable();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send(1'b0, 8'h55, 1'b1);
      n_checks++;
      if (OutData !== 8'h55) begin n_fail++; $display("FAIL dis_data[%0d]: got %h want 55", i, OutData); end
    end
    send(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (OutData !== 8'hC0) begin n_fail++; $display("FAIL dis_resume: got %h want c0", OutData); end
    idle();
  endtask

  task automatic test_ts_abort();
    logic       ks [0:7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] ds [0:7] = '{8'hBC, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hBC, 8'h1C};
    logic [1:0] es [0:7] = '{2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd2};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(ks[i], ds[i], 1'b0);
      n_checks++;
      if (OutData !== ds[i] || CtrlState !== es[i]) begin
        n_fail++;
        $display("FAIL abort[%0d]: got d=%h st=%0d want d=%h st=%0d", i, OutData, CtrlState, ds[i], es[i]);
      end
    end
    n_checks++;
    if (LfsrState !== 16'hFFFF) begin n_fail++; $display("FAIL abort_lfsr: got %h want ffff", LfsrState); end
    idle();
  endtask

  task automatic test_bubbles();
    do_reset();
    send(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (OutData !== 8'hFF) begin n_fail++; $display("FAIL bub_first: got %h want ff", OutData); end
    for (int i = 0; i < 3; i++) begin
      idle();
      n_checks++;
      if (OutValid !== 1'b0 || OutData !== 8'hFF || LfsrState !== 16'hE817) begin
        n_fail++;
        $display("FAIL bub_gap[%0d]: got v=%b d=%h lfsr=%h want v=0 d=ff lfsr=e817", i, OutValid, OutData, LfsrState);
      end
    end
    send(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (OutValid !== 1'b1 || OutData !== 8'h17) begin
      n_fail++; $display("FAIL bub_second: got v=%b d=%h want v=1 d=17", OutValid, OutData);
    end
    idle();
    #2;
    notResetPci = 1'b0;
    #1;
    n_checks++;
    if (LfsrState !== 16'hFFFF || OutData !== 8'h00 || CtrlState !== 2'd0) begin
      n_fail++; $display("FAIL bub_rst: got lfsr=%h d=%h st=%0d want ffff 00 0", LfsrState, OutData, CtrlState);
    end
    @(negedge ClkPci);
    notResetPci = 1'b1;
    send(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (OutData !== 8'hFF) begin n_fail++; $display("FAIL bub_after_rst: got %h want ff", OutData); end
    idle();
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_skp();
    test_ts();
    test_disable();
    test_ts_abort();
    test_bubbles();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
